// File: rtl/selen_wb_ram_slave.sv
// selen_wb_ram_slave: Wishbone B4 pipelined slave backed by word-addressed on-chip RAM
// Ports: wb_clk_i/wb_rst_i clock and sync active-high reset; wb_adr_i/wb_dat_i/wb_sel_i/wb_we_i/
// wb_cyc_i/wb_stb_i request; wb_stall_o throttle; wb_ack_o/wb_err_o/wb_dat_o response;
// wb_rty_o tied low; wb_lock_i/wb_tga_i/wb_tgc_i ignored.
module selen_wb_ram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BE_WIDTH = 4,
  parameter int MEM_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [BE_WIDTH-1:0]   wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic                  wb_stall_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  input  logic                  wb_lock_i,
  input  logic                  wb_tga_i,
  input  logic                  wb_tgc_i
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(MAX_OUT + 1);
  logic [ADDR_WIDTH-1:0] off;
  logic [AW-1:0] idx;
  logic ok, acc, resp, unused;
  logic [CW-1:0] cnt;
  logic [LATENCY-1:0] pv, pe, pr;
  logic [DATA_WIDTH-1:0] pd [LATENCY];
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  assign off = wb_adr_i - BASE_ADDR;
  assign ok = wb_adr_i[1:0] == 2'b00 && off[ADDR_WIDTH-1:AW+2] == '0;
  assign idx = off[AW+1:2];
  // stall comes from the registered count only; a response this cycle does not free a slot until the next
  assign wb_stall_o = wb_cyc_i && cnt == CW'(MAX_OUT);
  assign acc = wb_cyc_i & wb_stb_i & ~wb_stall_o & ~wb_rst_i;
  assign resp = wb_cyc_i & ~wb_rst_i & pv[LATENCY-1];
  assign wb_ack_o = resp & ~pe[LATENCY-1];
  assign wb_err_o = resp & pe[LATENCY-1];
  assign wb_dat_o = (wb_ack_o & pr[LATENCY-1]) ? pd[LATENCY-1] : '0;
  assign wb_rty_o = 1'b0;
  assign unused = ^{wb_lock_i, wb_tga_i, wb_tgc_i, off[1:0]};
  always_ff @(posedge wb_clk_i)
    if (acc && ok && wb_we_i)
      for (int i = 0; i < BE_WIDTH; i++)
        if (wb_sel_i[i]) mem[idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
  // dropping cyc aborts everything in flight; writes already done stay in RAM
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !wb_cyc_i) begin
      pv <= '0;
      cnt <= '0;
    end else begin
      pv[0] <= acc;
      for (int i = 1; i < LATENCY; i++) pv[i] <= pv[i-1];
      cnt <= cnt + CW'(acc) - CW'(resp);
    end
    pe[0] <= ~ok;
    pr[0] <= ~wb_we_i;
    pd[0] <= (ok && !wb_we_i) ? mem[idx] : '0;
    for (int i = 1; i < LATENCY; i++) begin
      pe[i] <= pe[i-1];
      pr[i] <= pr[i-1];
      pd[i] <= pd[i-1];
    end
  end
endmodule

// File: tb/tb_selen_wb_ram_slave.sv
// tb_selen_wb_ram_slave: directed bench with a transaction-level reference model
module tb_selen_wb_ram_slave;
  localparam int L = 2;
  localparam int M = 2;
  localparam int W = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;
  typedef struct {
    int due;
    logic err;
    logic rd;
    logic known;
    logic [31:0] d;
  } rsp_t;
  logic clk = 0, rst = 1, cyc = 0, stb = 0, we = 0;
  logic [31:0] adr = 0, dat_i = 0;
  logic [3:0] sel = 0;
  logic [31:0] dat_o;
  logic stall, ack, err, rty;
  int checks = 0, errors = 0, acks = 0, errs = 0, cycle = 0;
  rsp_t q[$];
  logic [31:0] mm [int];
  logic x_stall, x_resp, x_e, x_k, ok;
  logic [31:0] x_d, off, cur;
  rsp_t r;
  int w;
  always #5 clk = ~clk;
  selen_wb_ram_slave #(.MEM_WORDS(W), .BASE_ADDR(BASE), .LATENCY(L), .MAX_OUT(M)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_stall_o(stall),
    .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_lock_i(1'b0), .wb_tga_i(1'b0),
    .wb_tgc_i(1'b0));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask
  // model: outstanding requests are a queue of responses stamped with their due cycle
  always @(negedge clk) begin
    x_stall = cyc && q.size() == M;
    x_resp = cyc && !rst && q.size() > 0 && q[0].due == cycle;
    x_e = 0;
    x_d = 0;
    x_k = 1;
    if (x_resp) begin
      x_e = q[0].err;
      x_d = (!q[0].err && q[0].rd) ? q[0].d : 32'h0;
      x_k = q[0].known;
    end
    chk("stall", {31'h0, stall}, {31'h0, x_stall});
    chk("ack", {31'h0, ack}, {31'h0, x_resp & ~x_e});
    chk("err", {31'h0, err}, {31'h0, x_resp & x_e});
    chk("rty", {31'h0, rty}, 32'h0);
    if (x_k) chk("dat", dat_o, x_d);
    if (ack) acks++;
    if (err) errs++;
    if (x_resp) void'(q.pop_front());
    if (rst || !cyc) q.delete();
    else if (stb && !x_stall) begin
      off = adr - BASE;
      ok = adr[1:0] == 2'b00 && off < W * 4;
      w = int'(off >> 2);
      r.due = cycle + L;
      r.err = !ok;
      r.rd = !we;
      r.known = !(ok && !we) || mm.exists(w);
      r.d = (ok && !we && mm.exists(w)) ? mm[w] : 32'h0;
      q.push_back(r);
      if (ok && we) begin
        cur = mm.exists(w) ? mm[w] : 32'h0;
        for (int i = 0; i < 4; i++) if (sel[i]) cur[8*i +: 8] = dat_i[8*i +: 8];
        mm[w] = cur;
      end
    end
    cycle++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    cyc = 1;
    stb = 0;
    repeat (n) tick();
  endtask
  task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic done;
    done = 0;
    cyc = 1;
    stb = 1;
    we = wr;
    adr = a;
    dat_i = d;
    sel = s;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      done = !stall;
      tick();
    end
    stb = 0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL req_timeout adr %h never accepted", a);
    end
  endtask
  task automatic get_resp(output logic e, output logic [31:0] d);
    logic got;
    got = 0;
    e = 1'bx;
    d = 'x;
    cyc = 1;
    stb = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (ack || err) begin
        got = 1;
        e = err;
        d = dat_o;
      end
      tick();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout no ack or err seen");
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic e);
    logic [31:0] dd;
    req(1, a, d, s);
    get_resp(e, dd);
  endtask
  task automatic rd(input logic [31:0] a, output logic e, output logic [31:0] d);
    req(0, a, 32'h0, 4'h0);
    get_resp(e, d);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic e;
    logic [31:0] d;
    logic [5:0] st;
    logic acc;
    int a0, e0, n;
    repeat (2) tick();
    @(negedge clk);
    chk("reset_flags", {28'h0, ack, err, stall, rty}, 32'h0);
    chk("reset_dat", dat_o, 32'h0);
    tick();
    rst = 0;
    idle(1);
    req(1, 32'h10, 32'hDEADBEEF, 4'hF);
    req(0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    chk("lat_wr_ack", {31'h0, ack}, 32'h1);
    tick();
    @(negedge clk);
    chk("lat_rd_ack", {31'h0, ack}, 32'h1);
    chk("lat_rd_dat", dat_o, 32'hDEADBEEF);
    tick();
    idle(3);
    wr(32'h20, 32'h11223344, 4'hF, e);
    wr(32'h20, 32'hAABBCCDD, 4'h5, e);
    chk("be_wr_err", {31'h0, e}, 32'h0);
    rd(32'h20, e, d);
    chk("be_dat", d, 32'h11BB33DD);
    for (int i = 0; i < 4; i++) wr(i * 4, 32'hC0DE0000 + i, 4'hF, e);
    a0 = acks;
    e0 = errs;
    st = 0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      cyc = 1;
      stb = n < 4;
      we = 0;
      adr = n * 4;
      sel = 4'hF;
      @(negedge clk);
      st = {st[4:0], stall};
      acc = stb && !stall;
      tick();
      if (acc) n++;
    end
    idle(4);
    chk("pipe_stall_pattern", {26'h0, st}, 32'b001001);
    chk("pipe_accepts", n, 4);
    chk("pipe_acks", acks - a0, 4);
    chk("pipe_errs", errs - e0, 0);
    rd(BASE + W * 4, e, d);
    chk("oob_err", {31'h0, e}, 32'h1);
    chk("oob_dat", d, 32'h0);
    wr(32'h2, 32'hFFFFFFFF, 4'hF, e);
    chk("misalign_err", {31'h0, e}, 32'h1);
    rd(32'h0, e, d);
    chk("misalign_word0_kept", d, 32'hC0DE0000);
    idle(2);
    a0 = acks;
    e0 = errs;
    req(0, 32'h0, 32'h0, 4'h0);
    req(0, 32'h4, 32'h0, 4'h0);
    cyc = 0;
    @(negedge clk);
    chk("abort_quiet", {29'h0, ack, err, stall}, 32'h0);
    tick();
    cyc = 1;
    stb = 1;
    we = 0;
    adr = 32'h8;
    @(negedge clk);
    chk("abort_no_stall", {31'h0, stall}, 32'h0);
    tick();
    stb = 0;
    get_resp(e, d);
    chk("abort_new_dat", d, 32'hC0DE0002);
    chk("abort_acks", acks - a0, 1);
    chk("abort_errs", errs - e0, 0);
    idle(2);
    req(1, 32'h30, 32'hCAFEF00D, 4'hF);
    rst = 1;
    @(negedge clk);
    chk("rst_no_ack", {31'h0, ack}, 32'h0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_flags", {28'h0, ack, err, stall, rty}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    tick();
    rd(32'h30, e, d);
    chk("rst_ram_kept", d, 32'hCAFEF00D);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
